// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/NOR with Zero flag; undefined controls yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a + (~b + 1'b1);
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters; one result slot
// is held until the owning requester accepts it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*4-1:0]     req_ctrl,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  busy
);

    state_e           state_q, state_d;
    req_idx_t         ptr_q, ptr_d;
    req_idx_t         gnt_q, gnt_d;
    req_idx_t         gnt_idx;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .ctrl   (ctrl_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        if (req_valid[0] && req_valid[1]) begin
            gnt_idx = ptr_q;
        end else if (req_valid[1]) begin
            gnt_idx = 1'b1;
        end else begin
            gnt_idx = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        ctrl_d    = ctrl_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (!rst && (req_valid != '0)) begin
                    req_ready[gnt_idx] = 1'b1;
                    gnt_d   = gnt_idx;
                    ptr_d   = ~gnt_idx;
                    ctrl_d  = gnt_idx ? req_ctrl[7:4] : req_ctrl[3:0];
                    a_d     = gnt_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                    b_d     = gnt_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = HOLD;
            end
            HOLD: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != IDLE);

endmodule
